// File: rtl/frame_watchdog.sv
// Frame-arrival watchdog: requests a fixed-width low-active reset when frames stop,
// waits a holdoff for the pipeline to restart, and latches a fault after repeated failures.
module frame_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 10_000_000,
    parameter int unsigned PULSE_CYC   = 200,
    parameter int unsigned HOLDOFF_CYC = 50_000_000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       frame_evt,
    output logic       rst_req_n,
    output logic       alive,
    output logic       fault,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StPulse,
        StHoldoff,
        StFault
    } state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HoldoffLast = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [3:0]       RetryMax    = 4'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             req_n_q, req_n_d;
    logic             alive_q, alive_d;
    logic             fault_q, fault_d;
    logic             evt_q, evt_d;
    logic             frame_edge;

    assign frame_edge = frame_evt & ~evt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        req_n_d = req_n_q;
        alive_d = alive_q;
        fault_d = fault_q;
        evt_d   = frame_evt;

        if (!enable) begin
            // Disabling always returns to a clean idle, truncating any active pulse.
            state_d = StIdle;
            cnt_d   = '0;
            retry_d = '0;
            req_n_d = 1'b1;
            alive_d = 1'b0;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    req_n_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StArmed;
                end
                StArmed: begin
                    if (frame_edge) begin
                        cnt_d   = '0;
                        retry_d = '0;
                        alive_d = 1'b1;
                    end else if (cnt_q == TimeoutLast) begin
                        alive_d = 1'b0;
                        cnt_d   = '0;
                        if (retry_q == RetryMax) begin
                            state_d = StFault;
                            fault_d = 1'b1;
                        end else begin
                            state_d = StPulse;
                            req_n_d = 1'b0;
                            retry_d = retry_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StPulse: begin
                    req_n_d = 1'b0;
                    if (cnt_q == PulseLast) begin
                        req_n_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StHoldoff;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StHoldoff: begin
                    if (frame_edge) begin
                        state_d = StArmed;
                        cnt_d   = '0;
                        retry_d = '0;
                        alive_d = 1'b1;
                    end else if (cnt_q == HoldoffLast) begin
                        state_d = StArmed;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StFault: begin
                    fault_d = 1'b1;
                    req_n_d = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    req_n_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            retry_q <= '0;
            req_n_q <= 1'b1;
            alive_q <= 1'b0;
            fault_q <= 1'b0;
            // A line already high when reset lifts must not look like a fresh frame.
            evt_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            req_n_q <= req_n_d;
            alive_q <= alive_d;
            fault_q <= fault_d;
            evt_q   <= evt_d;
        end
    end

    assign rst_req_n = req_n_q;
    assign alive     = alive_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule
